// File: rtl/main_memory_model.sv
// ---------------------------------------------------------------------------
// main_memory_model
//
// Word-addressed backing store that sits behind the cache controller's
// main-memory port. Stores commit immediately. Line-fill reads go through a
// fixed-latency, in-order pipeline and are admitted against a credit count.
//
// Optional build macro: MEM_RANDOM_STALL_EN
//   Defined   - a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded with
//               STALL_SEED) additionally deasserts memory_read_ready in about
//               one cycle out of four. Credit, latency and ordering are
//               unchanged.
//   Undefined - ready is purely credit based and no LFSR exists.
//
// Ports:
//   clk                     in   rising-edge clock
//   rst                     in   asynchronous, active-low reset
//   memory_addr             in   word address for a read or a write
//   memory_write_en         in   write strobe, committed at this edge
//   memory_write_data       in   write data
//   memory_read_addr_valid  in   read request present on memory_addr
//   memory_read_ready       out  a read is accepted this cycle if requested
//   memory_read_valid       out  one-cycle pulse per returned read
//   memory_read_data        out  returned word (holds while valid is low)
//   o_dbg_outstanding       out  accepted reads whose data is not yet out
//
// Handshake: a read is accepted at a rising edge where
// memory_read_addr_valid and memory_read_ready are both 1. The request side
// may hold valid high; every cycle with ready high then accepts one read.
// The return path has no back-pressure: memory_read_valid pulses exactly
// READ_LATENCY cycles after the accepting edge, in acceptance order.
//
// The array is not reset and is not preloaded here; INIT_FILE names the hex
// image that the implementation / simulation flow binds to the array.
// ---------------------------------------------------------------------------
module main_memory_model #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          WORD_WIDTH      = 32,
    parameter int          MEM_ADDR_BITS   = 16,
    parameter int          READ_LATENCY    = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter string       INIT_FILE       = "",
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDR_WIDTH-1:0]                  memory_addr,
    input  logic                                   memory_write_en,
    input  logic [WORD_WIDTH-1:0]                  memory_write_data,
    input  logic                                   memory_read_addr_valid,
    output logic                                   memory_read_ready,
    output logic                                   memory_read_valid,
    output logic [WORD_WIDTH-1:0]                  memory_read_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_dbg_outstanding
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [WORD_WIDTH-1:0]                   r_mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0]                w_index;
    logic [WORD_WIDTH-1:0]                   w_rd_word;
    logic                                    w_accept;
    logic                                    w_return;
    logic                                    w_stall;
    logic [CNT_W-1:0]                        r_count;
    logic [CNT_W-1:0]                        w_count_next;
    logic                                    r_ready;
    logic [READ_LATENCY-1:0]                 r_pipe_valid;
    logic [READ_LATENCY-1:0][WORD_WIDTH-1:0] r_pipe_data;
    logic [READ_LATENCY-1:0]                 w_stage_in_valid;
    logic [READ_LATENCY-1:0][WORD_WIDTH-1:0] w_stage_in_data;
    logic                                    w_unused_cfg;

    // Upper address bits are ignored on purpose, so addresses alias.
    assign w_index = memory_addr[MEM_ADDR_BITS-1:0];

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_addr_alias
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^memory_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

    // Configuration values that drive no logic in every build.
    assign w_unused_cfg = (STALL_SEED != 16'h0000) ^ (INIT_FILE == "");

    // ---------------------------------------------------------------------
    // Storage. There is a single address port, so a read that coincides with
    // a write always targets the written word and sees the new data.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (memory_write_en) begin
            r_mem[w_index] <= memory_write_data;
        end
    end

    assign w_rd_word = memory_write_en ? memory_write_data : r_mem[w_index];

    // ---------------------------------------------------------------------
    // Read pipeline: stage 0 loads on accept, the last stage is the output.
    // Data registers only load behind a valid entry so the output word holds
    // its last value between pulses.
    // ---------------------------------------------------------------------
    assign w_accept = memory_read_addr_valid && r_ready;

    always_comb begin
        w_stage_in_valid    = '0;
        w_stage_in_data     = '0;
        w_stage_in_valid[0] = w_accept;
        w_stage_in_data[0]  = w_rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_stage_in_valid[i] = r_pipe_valid[i-1];
            w_stage_in_data[i]  = r_pipe_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_valid <= '0;
            r_pipe_data  <= '0;
        end else begin
            r_pipe_valid <= w_stage_in_valid;
            for (int i = 0; i < READ_LATENCY; i++) begin
                if (w_stage_in_valid[i]) begin
                    r_pipe_data[i] <= w_stage_in_data[i];
                end
            end
        end
    end

    // A credit is released at the edge that moves a read into the output
    // stage, so with MAX_OUTSTANDING == READ_LATENCY a continuous stream of
    // accepts never runs out of credit.
    assign w_return = w_stage_in_valid[READ_LATENCY-1];

    // ---------------------------------------------------------------------
    // Credit counter and registered ready.
    // ---------------------------------------------------------------------
    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_return) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_accept && w_return) begin
            w_count_next = r_count - 1'b1;
        end
    end

`ifdef MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= STALL_SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // The stall decision uses the LFSR value loaded at the same edge that
    // loads ready, so ready is low for the cycle that value is held.
    assign w_stall = (w_lfsr_next[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next < MAX_CNT) && !w_stall;
        end
    end

    assign memory_read_ready = r_ready;
    assign memory_read_valid = r_pipe_valid[READ_LATENCY-1];
    assign memory_read_data  = r_pipe_data[READ_LATENCY-1];
    assign o_dbg_outstanding = r_count;

endmodule

// File: tb/tb_main_memory_model.sv
// ---------------------------------------------------------------------------
// tb_main_memory_model
//
// Directed bench for main_memory_model. u_dut uses the default configuration
// (READ_LATENCY=4, MAX_OUTSTANDING=4); u_dut_credit uses MAX_OUTSTANDING=2 to
// exercise the credit limit. Inputs change on the falling edge, registered
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_main_memory_model;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;

    // default-configuration DUT
    logic [31:0] memory_addr;
    logic        memory_write_en;
    logic [31:0] memory_write_data;
    logic        memory_read_addr_valid;
    logic        memory_read_ready;
    logic        memory_read_valid;
    logic [31:0] memory_read_data;
    logic [2:0]  dbg_outstanding;

    // credit-limited DUT
    logic [31:0] c_addr;
    logic        c_write_en;
    logic [31:0] c_write_data;
    logic        c_read_addr_valid;
    logic        c_read_ready;
    logic        c_read_valid;
    logic [31:0] c_read_data;
    logic [1:0]  c_dbg_outstanding;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        mon_en   = 1'b0;
    logic        mon_exp_v;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    // credit DUT, observed after edges E1..E10 with valid held high
    int exp_c_ready [10] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    int exp_c_count [10] = '{1, 2, 2, 1, 1, 2, 2, 1, 1, 2};
    int exp_c_valid [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    main_memory_model u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .memory_addr            (memory_addr),
        .memory_write_en        (memory_write_en),
        .memory_write_data      (memory_write_data),
        .memory_read_addr_valid (memory_read_addr_valid),
        .memory_read_ready      (memory_read_ready),
        .memory_read_valid      (memory_read_valid),
        .memory_read_data       (memory_read_data),
        .o_dbg_outstanding      (dbg_outstanding)
    );

    main_memory_model #(
        .MEM_ADDR_BITS   (8),
        .READ_LATENCY    (4),
        .MAX_OUTSTANDING (2)
    ) u_dut_credit (
        .clk                    (clk),
        .rst                    (rst),
        .memory_addr            (c_addr),
        .memory_write_en        (c_write_en),
        .memory_write_data      (c_write_data),
        .memory_read_addr_valid (c_read_addr_valid),
        .memory_read_ready      (c_read_ready),
        .memory_read_valid      (c_read_valid),
        .memory_read_data       (c_read_data),
        .o_dbg_outstanding      (c_dbg_outstanding)
    );

    // ---------------- clock / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: valid must pulse exactly in the cycles the queue predicts.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            check_eq("read_valid", {31'd0, memory_read_valid}, {31'd0, mon_exp_v});
            if (mon_exp_v) begin
                check_eq("read_data", memory_read_data, exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle on the default DUT; a read pushes its expected word.
    task automatic drive(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                         input logic rv_i, input logic [31:0] exp_i);
        @(negedge clk);
        if (rv_i) begin
            check_eq("read_ready", {31'd0, memory_read_ready}, 32'd1);
            exp_q.push_back(exp_i);
            exp_cyc_q.push_back(cyc + LAT);
        end
        memory_write_en        = we_i;
        memory_addr            = a_i;
        memory_write_data      = wd_i;
        memory_read_addr_valid = rv_i;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst                    = 1'b1;
        memory_addr            = '0;
        memory_write_en        = 1'b0;
        memory_write_data      = '0;
        memory_read_addr_valid = 1'b0;
        c_addr                 = '0;
        c_write_en             = 1'b0;
        c_write_data           = '0;
        c_read_addr_valid      = 1'b0;
        #2 rst = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_valid", {31'd0, memory_read_valid}, 32'd0);
        check_eq("rst_data", memory_read_data, 32'd0);
        check_eq("rst_ready", {31'd0, memory_read_ready}, 32'd0);
        check_eq("rst_count", {29'd0, dbg_outstanding}, 32'd0);
        check_eq("rst_c_ready", {31'd0, c_read_ready}, 32'd0);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, memory_read_ready}, 32'd1);
        check_eq("post_rst_count", {29'd0, dbg_outstanding}, 32'd0);

        // write then read
        drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
        drive(1'b0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF);
        idle(6);

        // line-fill burst: preload then 16 back-to-back reads
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h40 + i, 32'h40 + i, 1'b0, 32'd0);
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h40 + i, 32'd0, 1'b1, 32'h40 + i);
        idle(6);

        // same-cycle hazard: write-first, later write does not leak in
        drive(1'b1, 32'h5, 32'h1, 1'b0, 32'd0);
        drive(1'b1, 32'h5, 32'h2, 1'b1, 32'h2);
        drive(1'b1, 32'h5, 32'h3, 1'b0, 32'd0);
        drive(1'b0, 32'h5, 32'd0, 1'b1, 32'h3);
        idle(6);

        // aliasing on the upper address bits
        drive(1'b1, 32'h0001_0007, 32'hA5, 1'b0, 32'd0);
        drive(1'b0, 32'h0000_0007, 32'd0, 1'b1, 32'hA5);
        drive(1'b1, 32'h0000_0007, 32'h5A, 1'b0, 32'd0);
        drive(1'b0, 32'hFFFF_0007, 32'd0, 1'b1, 32'h5A);
        idle(6);

        // reset mid-flight: three accepted reads are dropped
        drive(1'b0, 32'h40, 32'd0, 1'b1, 32'h40);
        drive(1'b0, 32'h41, 32'd0, 1'b1, 32'h41);
        drive(1'b0, 32'h42, 32'd0, 1'b1, 32'h42);
        @(negedge clk);
        memory_read_addr_valid = 1'b0;
        rst                    = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check_eq("midrst_valid", {31'd0, memory_read_valid}, 32'd0);
        check_eq("midrst_ready", {31'd0, memory_read_ready}, 32'd0);
        check_eq("midrst_count", {29'd0, dbg_outstanding}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", {31'd0, memory_read_ready}, 32'd1);
        check_eq("rel_valid", {31'd0, memory_read_valid}, 32'd0);
        check_eq("rel_count", {29'd0, dbg_outstanding}, 32'd0);
        idle(8);

        // credit limit on the MAX_OUTSTANDING=2 instance
        @(negedge clk);
        c_write_en   = 1'b1;
        c_addr       = 32'h33;
        c_write_data = 32'h1234_5678;
        @(negedge clk);
        check_eq("credit_ready_idle", {31'd0, c_read_ready}, 32'd1);
        c_write_en        = 1'b0;
        c_read_addr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("credit_ready", {31'd0, c_read_ready}, exp_c_ready[k]);
            check_eq("credit_count", {30'd0, c_dbg_outstanding}, exp_c_count[k]);
            check_eq("credit_valid", {31'd0, c_read_valid}, exp_c_valid[k]);
            if (exp_c_valid[k] != 0) check_eq("credit_data", c_read_data, 32'h1234_5678);
        end
        c_read_addr_valid = 1'b0;
        repeat (6) @(negedge clk);

        check_eq("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/main_memory_model.md
Name: main_memory_model

Overview:
Word-addressed backing store that sits directly downstream of the cache controller's main-memory port. It serves the controller's line-fill reads through a fixed-latency, in-order read pipeline with credit-limited acceptance, and it commits write-through stores immediately. It is a synthesizable behavioural model used in simulation and FPGA builds of the compressed-cache system.

Parameters:
ADDR_WIDTH, 32, width of the word address presented by the controller
WORD_WIDTH, 32, data word width
MEM_ADDR_BITS, 16, number of low word-address bits used to index the array (depth = 2^MEM_ADDR_BITS words)
READ_LATENCY, 4, cycles from read acceptance to read data valid (legal range 1..16)
MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads (legal range 1..READ_LATENCY)
INIT_FILE, "", hex image loaded at time zero if non-empty; otherwise the contents are undefined
STALL_SEED, 16'hACE1, LFSR seed used only with the optional feature (must be non-zero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
memory_addr  input  ADDR_WIDTH  word address for a read or a write
memory_write_en  input  1  write strobe; the word is written at this clock edge
memory_write_data  input  WORD_WIDTH  write data
memory_read_addr_valid  input  1  read request present on memory_addr
memory_read_ready  output  1  model can accept a read this cycle
memory_read_valid  output  1  memory_read_data holds a returned word (one-cycle pulse per read)
memory_read_data  output  WORD_WIDTH  returned read data

Behaviour:
- Reset (rst low, asynchronous): memory_read_valid=0, memory_read_data=0, memory_read_ready=0, outstanding count=0, all pipeline stages invalid. The array contents are not reset.
- Reset asserted mid-operation: all in-flight reads are dropped and never returned. The first cycle after release has ready=1 and valid=0.
- Index: array index = memory_addr[MEM_ADDR_BITS-1:0]. Upper address bits are ignored, so addresses alias.
- Write: when memory_write_en=1 at a rising edge, array[index] <= memory_write_data. Writes need no handshake and are never stalled.
- Read accept: a read is accepted at a rising edge when memory_read_addr_valid=1 and memory_read_ready=1. At most one read is accepted per cycle. A held valid with ready held high produces one accept per cycle.
- Read data capture: data is sampled at the accept edge. If a write to the same index occurs in the same cycle, the read returns the new write data (write-first). Writes after the accept edge do not affect that read.
- Return: an accept at edge N produces memory_read_valid=1 with the data during the cycle after edge N+READ_LATENCY-1, i.e. exactly READ_LATENCY cycles later. Returns are strictly in order. There is no back-pressure on the return path.
- Pipeline: READ_LATENCY-deep shift register of {valid, data}. Stage 0 is loaded on accept; the last stage drives the outputs. When memory_read_valid=0, memory_read_data holds its last value.
- Credit counter: width is clog2(MAX_OUTSTANDING+1).
  - Increments on an accept edge with no return.
  - Decrements on a return edge with no accept.
  - Unchanged when both occur in the same edge.
- Ready: memory_read_ready is a register. Its next value = (next count < MAX_OUTSTANDING). Reaching full deasserts ready in the following cycle, with no overshoot. When MAX_OUTSTANDING >= READ_LATENCY, ready never drops in the base configuration.
- Simultaneous read and write to different indices in the same cycle: both take effect.

Optional Feature:
MEM_RANDOM_STALL_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is reset to STALL_SEED and advances every cycle. memory_read_ready is additionally forced to 0 in any cycle where lfsr[1:0]==2'b00 at the preceding edge, giving a deterministic pseudo-random ~25% stall. Credit, latency and ordering rules are unchanged.
- Undefined: no LFSR is present and ready is purely credit-based.

Test Plan:
- Write then read: write 32'hDEADBEEF to addr 0x10, then hold a read of 0x10 for one accept -> with READ_LATENCY=4, valid pulses 4 cycles after accept with data 32'hDEADBEEF.
- Line-fill burst: preload addr 0x40..0x4F with value=addr, hold addr_valid for 16 accepts at consecutive addresses -> 16 valid pulses in order, data 0x40..0x4F, no gaps, ready never low.
- Credit limit: MAX_OUTSTANDING=2, READ_LATENCY=4, hold addr_valid -> ready drops after 2 accepts, re-rises once the first return occurs, and the count never exceeds 2.
- Same-cycle hazard: array[5]=1; in one cycle write 5<=2 and accept read 5; next cycle write 5<=3 -> the read returns 2.
- Reset mid-flight: accept 3 reads, pulse rst low for 1 cycle before any return -> no valid is ever seen, ready=1 after release, count=0.
- Aliasing: MEM_ADDR_BITS=16, write 0x0001_0007<=0xA5, read 0x7 -> returns 0xA5. With MEM_RANDOM_STALL_EN defined, repeat the burst test -> all 16 words still return in order.
